// File: rtl/ram_ctl_pkg.sv
// Shared types and constants for the s3board dual async SRAM controller.
// Holds the FSM encoding, lane-to-chip mapping and SRAM geometry.
package ram_ctl_pkg;

  localparam int RAM_AW = 18;
  localparam int RAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WS   = 3'd2,
    WP   = 3'd3,
    WH   = 3'd4,
    DONE = 3'd5
  } state_t;

  // ram1 carries bits [15:0], ram2 carries bits [31:16]
  localparam int RAM1_LB_LANE = 0;
  localparam int RAM1_UB_LANE = 1;
  localparam int RAM2_LB_LANE = 2;
  localparam int RAM2_UB_LANE = 3;

  function automatic logic chip_on(
    input logic [3:0] be,
    input int         lb,
    input int         ub
  );
    return be[lb] | be[ub];
  endfunction

endpackage

// File: rtl/ram_ctl_s3board.sv
// Request/ack bus to dual IS61LV25616 async SRAM strobes (s3board).
// Ports: req/write/addr/wdata/be in, rdata/ack/busy out, SRAM pins.
module ram_ctl_s3board
  import ram_ctl_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  inout  wire  [RAM_DW-1:0] ram1_io,
  inout  wire  [RAM_DW-1:0] ram2_io,
  output logic              ram1_ce_n,
  output logic              ram1_ub_n,
  output logic              ram1_lb_n,
  output logic              ram2_ce_n,
  output logic              ram2_ub_n,
  output logic              ram2_lb_n
);

  localparam int MAXW =
    (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW = $clog2(MAXW + 1);

  localparam logic [CW-1:0] RD_LOAD  = CW'(READ_WAIT);
  localparam logic [CW-1:0] WR_LOAD  = CW'(WRITE_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   wdata_q;
  logic          io_oe;

  assign ram1_io = io_oe ? wdata_q[RAM_DW-1:0] : 'z;
  assign ram2_io = io_oe ? wdata_q[2*RAM_DW-1:RAM_DW] : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata_q   <= '0;
      io_oe     <= 1'b0;
      rdata     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      ram_a     <= '0;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram1_ce_n <= 1'b1;
      ram1_ub_n <= 1'b1;
      ram1_lb_n <= 1'b1;
      ram2_ce_n <= 1'b1;
      ram2_ub_n <= 1'b1;
      ram2_lb_n <= 1'b1;
    end else begin
      ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            busy      <= 1'b1;
            ram_a     <= addr;
            wdata_q   <= wdata;
            ram1_lb_n <= ~be[RAM1_LB_LANE];
            ram1_ub_n <= ~be[RAM1_UB_LANE];
            ram2_lb_n <= ~be[RAM2_LB_LANE];
            ram2_ub_n <= ~be[RAM2_UB_LANE];
            ram1_ce_n <=
              ~chip_on(be, RAM1_LB_LANE, RAM1_UB_LANE);
            ram2_ce_n <=
              ~chip_on(be, RAM2_LB_LANE, RAM2_UB_LANE);
            if (write) begin
              state <= WS;
              io_oe <= 1'b1;
            end else begin
              state    <= RD;
              ram_oe_n <= 1'b0;
              cnt      <= RD_LOAD;
            end
          end
        end
        RD: begin
          if (cnt == CNT_LAST) begin
            rdata     <= {ram2_io, ram1_io};
            state     <= DONE;
            ack       <= 1'b1;
            cnt       <= '0;
            ram_oe_n  <= 1'b1;
            ram1_ce_n <= 1'b1;
            ram1_ub_n <= 1'b1;
            ram1_lb_n <= 1'b1;
            ram2_ce_n <= 1'b1;
            ram2_ub_n <= 1'b1;
            ram2_lb_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WS: begin
          state    <= WP;
          cnt      <= WR_LOAD;
          ram_we_n <= 1'b0;
        end
        WP: begin
          if (cnt == CNT_LAST) begin
            state    <= WH;
            cnt      <= '0;
            ram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WH: begin
          // data held one cycle past we_n rise for hold time
          state     <= DONE;
          ack       <= 1'b1;
          io_oe     <= 1'b0;
          ram1_ce_n <= 1'b1;
          ram1_ub_n <= 1'b1;
          ram1_lb_n <= 1'b1;
          ram2_ce_n <= 1'b1;
          ram2_ub_n <= 1'b1;
          ram2_lb_n <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctl_s3board.sv
// Self-checking bench for ram_ctl_s3board with behavioural SRAMs.
// Two DUTs: default waits (A) and READ_WAIT=1/WRITE_WAIT=4 (B).
module tb_ram_ctl_s3board;

  localparam int A_RW = 2;
  localparam int A_WW = 2;
  localparam int B_RW = 1;
  localparam int B_WW = 4;

  logic clk;
  logic reset;

  logic        a_req, a_write;
  logic [17:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [31:0] a_rdata;
  logic        a_ack, a_busy;
  logic [17:0] a_ram_a;
  logic        a_oe_n, a_we_n;
  wire  [15:0] a_io1, a_io2;
  logic        a_ce1, a_ub1, a_lb1;
  logic        a_ce2, a_ub2, a_lb2;

  logic        b_req, b_write;
  logic [17:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic [31:0] b_rdata;
  logic        b_ack, b_busy;
  logic [17:0] b_ram_a;
  logic        b_oe_n, b_we_n;
  wire  [15:0] b_io1, b_io2;
  logic        b_ce1, b_ub1, b_lb1;
  logic        b_ce2, b_ub2, b_lb2;

  int n_chk;
  int n_fail;

  ram_ctl_s3board #(.READ_WAIT(A_RW), .WRITE_WAIT(A_WW)) dut_a (
    .clk(clk), .reset(reset),
    .req(a_req), .write(a_write), .addr(a_addr),
    .wdata(a_wdata), .be(a_be),
    .rdata(a_rdata), .ack(a_ack), .busy(a_busy),
    .ram_a(a_ram_a), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n),
    .ram1_io(a_io1), .ram2_io(a_io2),
    .ram1_ce_n(a_ce1), .ram1_ub_n(a_ub1), .ram1_lb_n(a_lb1),
    .ram2_ce_n(a_ce2), .ram2_ub_n(a_ub2), .ram2_lb_n(a_lb2)
  );

  ram_ctl_s3board #(.READ_WAIT(B_RW), .WRITE_WAIT(B_WW)) dut_b (
    .clk(clk), .reset(reset),
    .req(b_req), .write(b_write), .addr(b_addr),
    .wdata(b_wdata), .be(b_be),
    .rdata(b_rdata), .ack(b_ack), .busy(b_busy),
    .ram_a(b_ram_a), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n),
    .ram1_io(b_io1), .ram2_io(b_io2),
    .ram1_ce_n(b_ce1), .ram1_ub_n(b_ub1), .ram1_lb_n(b_lb1),
    .ram2_ce_n(b_ce2), .ram2_ub_n(b_ub2), .ram2_lb_n(b_lb2)
  );

  // behavioural async SRAM pairs
  logic [15:0] a_m1 [0:(1<<18)-1];
  logic [15:0] a_m2 [0:(1<<18)-1];
  logic [15:0] b_m1 [0:(1<<18)-1];
  logic [15:0] b_m2 [0:(1<<18)-1];

  assign a_io1 = (!a_ce1 && !a_oe_n && a_we_n) ? a_m1[a_ram_a] : 'z;
  assign a_io2 = (!a_ce2 && !a_oe_n && a_we_n) ? a_m2[a_ram_a] : 'z;
  assign b_io1 = (!b_ce1 && !b_oe_n && b_we_n) ? b_m1[b_ram_a] : 'z;
  assign b_io2 = (!b_ce2 && !b_oe_n && b_we_n) ? b_m2[b_ram_a] : 'z;

  always @(negedge clk) begin
    if (!a_ce1 && !a_we_n) begin
      if (!a_lb1) a_m1[a_ram_a][7:0]  <= a_io1[7:0];
      if (!a_ub1) a_m1[a_ram_a][15:8] <= a_io1[15:8];
    end
    if (!a_ce2 && !a_we_n) begin
      if (!a_lb2) a_m2[a_ram_a][7:0]  <= a_io2[7:0];
      if (!a_ub2) a_m2[a_ram_a][15:8] <= a_io2[15:8];
    end
    if (!b_ce1 && !b_we_n) begin
      if (!b_lb1) b_m1[b_ram_a][7:0]  <= b_io1[7:0];
      if (!b_ub1) b_m1[b_ram_a][15:8] <= b_io1[15:8];
    end
    if (!b_ce2 && !b_we_n) begin
      if (!b_lb2) b_m2[b_ram_a][7:0]  <= b_io2[7:0];
      if (!b_ub2) b_m2[b_ram_a][15:8] <= b_io2[15:8];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference memory for DUT A: word address -> 32-bit contents
  logic [31:0] model_a [int];

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d, input logic [3:0] be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic access(
    input bit s, input bit wr, input logic [17:0] ad,
    input logic [31:0] wd, input logic [3:0] be,
    output int lat, output logic [31:0] rd,
    output logic [3:0] lanes, output logic [1:0] ces
  );
    @(posedge clk); #1;
    if (!s) begin
      a_req = 1; a_write = wr; a_addr = ad; a_wdata = wd; a_be = be;
    end else begin
      b_req = 1; b_write = wr; b_addr = ad; b_wdata = wd; b_be = be;
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    lat = -1; rd = '0; lanes = '0; ces = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!s) begin
        lanes |= {~a_ub2, ~a_lb2, ~a_ub1, ~a_lb1};
        ces   |= {~a_ce2, ~a_ce1};
        if (a_ack) begin lat = k; rd = a_rdata; break; end
      end else begin
        lanes |= {~b_ub2, ~b_lb2, ~b_ub1, ~b_lb1};
        ces   |= {~b_ce2, ~b_ce1};
        if (b_ack) begin lat = k; rd = b_rdata; break; end
      end
    end
  endtask

  task automatic run(
    input string tag, input bit s, input bit wr,
    input logic [17:0] ad, input logic [31:0] wd,
    input logic [3:0] be, input int exp_lat,
    input logic [31:0] exp_rd
  );
    int          lat;
    logic [31:0] rd;
    logic [3:0]  lanes;
    logic [1:0]  ces;
    access(s, wr, ad, wd, be, lat, rd, lanes, ces);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, " lanes"}, 64'(lanes), 64'(be));
    chk({tag, " ce"}, 64'(ces), 64'({|be[3:2], |be[1:0]}));
  endtask

  typedef struct {
    string       tag;
    bit          s;
    bit          wr;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat;
    int          acks, idle, viol, extra;
    logic [31:0] last_a;
    logic [17:0] pa;
    logic        poe, pwe;
    logic [17:0] ad;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          wr;

    n_chk = 0; n_fail = 0;
    reset = 1;
    a_req = 0; a_write = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 0; b_write = 0; b_addr = '0; b_wdata = '0; b_be = '0;

    vecs[0] = '{"t1 wr",  0, 1, 18'o1234, 32'h89AB_CDEF, 4'hF, 5, 32'h0};
    vecs[1] = '{"t1 rd",  0, 0, 18'o1234, 32'h0, 4'hF, 3, 32'h89AB_CDEF};
    vecs[2] = '{"t2 wr0", 0, 1, 18'd5, 32'h0, 4'hF, 5, 32'h89AB_CDEF};
    vecs[3] = '{"t2 wr1", 0, 1, 18'd5, 32'h1122_3344, 4'b0101, 5,
                32'h89AB_CDEF};
    vecs[4] = '{"t2 rd",  0, 0, 18'd5, 32'h0, 4'hF, 3, 32'h0022_0044};
    vecs[5] = '{"t3 wr7", 0, 1, 18'd7, 32'hDEAD_BEEF, 4'b0011, 5,
                32'h0022_0044};
    vecs[6] = '{"t3 wr8", 0, 1, 18'd8, 32'hCAFE_F00D, 4'b0000, 5,
                32'h0022_0044};
    vecs[7] = '{"t6 wr",  1, 1, 18'o777777, 32'hFFFF_0000, 4'hF, 7,
                32'h0};
    vecs[8] = '{"t6 rd",  1, 0, 18'o777777, 32'h0, 4'hF, 2,
                32'hFFFF_0000};

    repeat (3) @(negedge clk);
    chk("rst a ack/busy", {a_ack, a_busy}, 2'b00);
    chk("rst a rdata", a_rdata, 32'h0);
    chk("rst a ram_a", a_ram_a, 18'h0);
    chk("rst a strobes",
        {a_oe_n, a_we_n, a_ce1, a_ub1, a_lb1, a_ce2, a_ub2, a_lb2},
        8'hFF);
    chk("rst b strobes",
        {b_oe_n, b_we_n, b_ce1, b_ub1, b_lb1, b_ce2, b_ub2, b_lb2},
        8'hFF);
    chk("rst b busy", b_busy, 1'b0);
    reset = 0;

    foreach (vecs[i])
      run(vecs[i].tag, vecs[i].s, vecs[i].wr, vecs[i].addr,
          vecs[i].wdata, vecs[i].be, vecs[i].lat, vecs[i].rdata);
    last_a = 32'h0022_0044;

    // prefill a small window, then random traffic against the model
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_a[i] = wd;
      run("fill", 0, 1, 18'(i), wd, 4'hF, A_WW + 3, last_a);
    end
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 18'($urandom_range(0, 15));
      if (wr) begin
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
        model_a[int'(ad)] = merge(model_a[int'(ad)], wd, be);
        run("rnd wr", 0, 1, ad, wd, be, A_WW + 3, last_a);
      end else begin
        last_a = model_a[int'(ad)];
        run("rnd rd", 0, 0, ad, 32'h0, 4'hF, A_RW + 1, last_a);
      end
    end

    // back-to-back reads with req held high
    @(posedge clk); #1;
    a_req = 1; a_write = 0; a_addr = 18'd1; a_be = 4'hF;
    acks = 0; idle = 0; viol = 0;
    pa = a_ram_a; poe = a_oe_n; pwe = a_we_n;
    for (int k = 0; k < 40 && acks < 3; k++) begin
      @(negedge clk);
      if (a_ram_a !== pa && !(poe && pwe)) viol++;
      pa = a_ram_a; poe = a_oe_n; pwe = a_we_n;
      if (acks > 0 && !a_busy) idle++;
      if (a_ack) begin
        acks++;
        chk("t4 rdata", a_rdata, model_a[acks]);
        if (acks < 3) a_addr = 18'(acks + 1);
        else a_req = 0;
      end
    end
    a_req = 0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack) extra++;
    end
    chk("t4 ack count", 64'(acks + extra), 64'd3);
    chk("t4 idle gaps", 64'(idle), 64'd2);
    chk("t4 addr stable", 64'(viol), 64'd0);
    last_a = model_a[3];

    // reset while the write pulse is active
    @(posedge clk); #1;
    a_req = 1; a_write = 1; a_addr = 18'd20;
    a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
    @(posedge clk); #1;
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5 in WP", a_we_n, 1'b0);
    reset = 1;
    #1;
    chk("t5 strobes",
        {a_oe_n, a_we_n, a_ce1, a_ub1, a_lb1, a_ce2, a_ub2, a_lb2},
        8'hFF);
    chk("t5 io1 released", a_io1 === 16'hFFFF, 1'b0);
    chk("t5 io2 released", a_io2 === 16'hFFFF, 1'b0);
    chk("t5 ack/busy", {a_ack, a_busy}, 2'b00);
    @(negedge clk);
    reset = 0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_ack) extra++;
    end
    chk("t5 no ack", 64'(extra), 64'd0);
    last_a = model_a[0];
    run("t5 rd0", 0, 0, 18'd0, 32'h0, 4'hF, A_RW + 1, last_a);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_ctl_s3board.md
Name: ram_ctl_s3board

Overview:
- Initiator side of the s3board dual IS61LV25616AL-10T asynchronous SRAM interface.
- Converts a single-clock 32-bit request/acknowledge bus from the memory subsystem into async SRAM strobes.
- Shared ram_a/ram_oe_n/ram_we_n drive both chips; ram1 holds bits [15:0] and ram2 holds bits [31:16].
- Sits between the CPU memory arbiter and the board SRAM pins, or the SRAM simulation model in benches.

Parameters:
- READ_WAIT, 2, cycles ce_n/oe_n held low before read data is captured; minimum 1.
- WRITE_WAIT, 2, cycles we_n held low during a write; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  1  request strobe; sampled only in IDLE
- write  input  1  1 = write, 0 = read; sampled with req
- addr  input  18  word address; sampled with req
- wdata  input  32  write data; sampled with req
- be  input  4  byte enables; be[0] = bits [7:0], be[3] = bits [31:24]
- rdata  output  32  read data; valid when ack=1 for a read
- ack  output  1  one-cycle completion pulse
- busy  output  1  high in every non-IDLE state
- ram_a  output  18  shared SRAM address
- ram_oe_n, ram_we_n  output  1 each  shared output-enable and write-enable
- ram1_io, ram2_io  inout  16 each  SRAM data; hi-Z unless driving a write
- ram1_ce_n, ram1_ub_n, ram1_lb_n  output  1 each  ram1 chip enable and byte lanes (be[1], be[0])
- ram2_ce_n, ram2_ub_n, ram2_lb_n  output  1 each  ram2 chip enable and byte lanes (be[3], be[2])

Behaviour:
- Reset (asynchronous, active-high; "Already decided" as fixed above):
  - ram_a=0, rdata=0, ack=0, busy=0.
  - All _n strobes =1; both io buses hi-Z; state=IDLE; wait counter=0.
- Reset mid-operation: strobes deassert immediately (asynchronously). The access is abandoned, no ack is issued, and SRAM contents are undefined for the aborted write.
- All strobe, address and io-enable outputs are registered; no combinational path from req to any pin.
- Sampling: in IDLE with req=1, register addr, wdata, be, write. Then:
  - lb_n = ~be[even lane], ub_n = ~be[odd lane].
  - chip ce_n = ~(either lane of that chip enabled).
  - be=0 performs a full timed cycle with no chip enabled and still acks.
- States:
  - IDLE: all strobes high, io hi-Z. req=1 goes to RD if write=0, otherwise to WS.
  - RD: ce_n and oe_n low (oe_n asserted together with ce_n), we_n high, io hi-Z. Stays READ_WAIT cycles. On the last cycle's clock edge, capture {ram2_io, ram1_io} into rdata, then go to DONE.
  - WS (write setup, 1 cycle): ce_n low, oe_n high, we_n high, io driven with latched data.
  - WP (write pulse, WRITE_WAIT cycles): we_n low, io driven.
  - WH (write hold, 1 cycle): we_n high, io still driven, ce_n low.
  - DONE (1 cycle): ack=1, all strobes high, io hi-Z. Go to IDLE.
- Latency, with req sampled at edge 0:
  - read: ack high in cycle READ_WAIT+1 (3 with defaults).
  - write: ack high in cycle WRITE_WAIT+3 (5 with defaults).
- Throughput: at least one idle cycle between accesses. req is ignored while busy=1, including in DONE; the requester must hold or re-assert it.
- Signal timing:
  - ram_a and byte lanes are stable from entry to RD/WS until DONE.
  - io is never driven while oe_n=0.
  - we_n never falls in the cycle that ram_a changes.
- rdata holds its last captured value until the next read completes; writes do not change it.
- Wait counter width is clog2(max(READ_WAIT, WRITE_WAIT)+1). The counter is loaded on state entry and counts down to 1.

Decomposition:
- Package ram_ctl_pkg holds:
  - state encoding localparams (IDLE, RD, WS, WP, WH, DONE);
  - lane-to-chip mapping constants;
  - RAM_AW=18 and RAM_DW=16.
- No sub-module: one FSM, one counter and the tristate enables, all in one file.
- The bench instantiates the existing s3board SRAM model on the pin side.

Test Plan:
1. Write addr=0o1234, wdata=0x89AB_CDEF, be=4'hF, then read addr=0o1234. Required: read returns rdata=0x89AB_CDEF; ack at cycle 5 (write) and cycle 3 (read).
2. Write addr=5, wdata=0, be=4'hF; write addr=5, wdata=0x1122_3344, be=4'b0101; read addr=5. Required: rdata=0x0022_0044; ram1_ub_n and ram2_ub_n high throughout the second write.
3. Write addr=7 with be=4'b0011. Required: ram2_ce_n stays 1 for the whole access. Then write addr=8 with be=0: ack still arrives after 5 cycles.
4. Hold req=1 continuously across three reads of addr 1, 2, 3. Required:
   - exactly three ack pulses;
   - one IDLE cycle between them;
   - ram_a changes only while we_n=oe_n=1.
5. Assert reset during the WP state of a write. Required: all _n strobes are 1 and io is hi-Z in the same cycle; no ack. A subsequent read of addr=0 completes normally.
6. Set READ_WAIT=1 and WRITE_WAIT=4, then write and read addr=0o777777 with data 0xFFFF_0000. Required: read ack at cycle 2, write ack at cycle 7, rdata=0xFFFF_0000.
